// File: rtl/brick_wall_logic_pkg.sv
// Shared definitions for the brick wall: game state codes, screen and wall
// geometry, ball radius, RGB565 colours, the per-row colour table and the
// (row, col) -> brick index mapping.
package brick_wall_logic_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_LOSE = 2'b10,
    GS_WIN  = 2'b11
  } game_state_e;

  localparam int unsigned H_VALID        = 640;
  localparam int unsigned V_VALID        = 480;
  localparam int unsigned N_ROWS         = 5;
  localparam int unsigned N_COLS         = 10;
  localparam int unsigned N_BRICKS       = 50;
  localparam int unsigned WALL_Y0        = 40;
  localparam int unsigned COL_PITCH_LOG2 = 6;
  localparam int unsigned ROW_PITCH_LOG2 = 5;
  localparam int unsigned BRICK_X_LO     = 2;   // x offset of left edge inside a column
  localparam int unsigned BRICK_X_HI     = 61;  // x offset of right edge inside a column
  localparam int unsigned BRICK_H_M1     = 23;  // brick height minus one
  localparam int unsigned BALL_RADIUS    = 5;

  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_ORANGE = 16'hFC00;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_BLACK  = 16'h0000;

  function automatic logic [15:0] row_color(input logic [2:0] row);
    logic [15:0] c;
    case (row)
      3'd0:    c = RGB_RED;
      3'd1:    c = RGB_ORANGE;
      3'd2:    c = RGB_YELLOW;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] brick_index(input logic [2:0] row, input logic [3:0] col);
    return 6'((int'(row) * N_COLS) + int'(col));
  endfunction

endpackage

// File: rtl/brick_wall_logic_geom.sv
// brick_geom: combinational brick bounding box for a (row, col) position.
// Ports:
//   row_i, col_i  brick row (0..4) and column (0..9)
//   bx0_o, bx1_o  inclusive left/right pixel x of the brick (11 bit)
//   by0_o, by1_o  inclusive top/bottom pixel y of the brick (11 bit)
module brick_geom
  import brick_wall_logic_pkg::*;
(
  input  logic [2:0]  row_i,
  input  logic [3:0]  col_i,
  output logic [10:0] bx0_o,
  output logic [10:0] bx1_o,
  output logic [10:0] by0_o,
  output logic [10:0] by1_o
);

  logic [10:0] col_base;
  logic [10:0] row_base;

  assign col_base = {1'b0, col_i, 6'd0};
  assign row_base = {3'b000, row_i, 5'd0};

  assign bx0_o = col_base + 11'(BRICK_X_LO);
  assign bx1_o = col_base + 11'(BRICK_X_HI);
  assign by0_o = row_base + 11'(WALL_Y0);
  assign by1_o = row_base + 11'(WALL_Y0 + BRICK_H_M1);

endmodule

// File: rtl/brick_wall_logic.sv
// brick_wall_logic: owns the 5x10 brick wall. Scans one brick per PLAY cycle
// for overlap with the ball, removes hit bricks, emits a one-cycle one-hot
// collision pulse, keeps score / bricks_left / win and renders brick pixels.
// Ports:
//   vga_clk, sys_rst_n   pixel clock, async active-low reset
//   pix_x, pix_y         current pixel coordinate
//   ball_x, ball_y       ball centre from the physics block
//   game_state           00 IDLE, 01 PLAY, 10 LOSE, 11 WIN
//   game_reset           synchronous restart request
//   brick_collision      one-hot hit pulse (one cycle)
//   brick_pix_data       RGB565 colour of a live brick under the pixel, else 0
//   score, bricks_left   bricks destroyed / bricks remaining
//   win_sig              high while no bricks remain
module brick_wall_logic
  import brick_wall_logic_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 10000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [1:0]  game_state,
  input  logic        game_reset,
  output logic [49:0] brick_collision,
  output logic [15:0] brick_pix_data,
  output logic [5:0]  score,
  output logic [5:0]  bricks_left,
  output logic        win_sig
);

  localparam int unsigned LW = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  logic [49:0]   alive_q, alive_d;
  logic [49:0]   coll_q, coll_d;
  logic [5:0]    score_q, score_d;
  logic [5:0]    left_q, left_d;
  logic          win_q, win_d;
  logic [2:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [LW-1:0] lock_q, lock_d;

  logic        play;
  logic [5:0]  scan_idx;
  logic [10:0] s_bx0, s_bx1, s_by0, s_by1;
  logic [10:0] ball_x_r, ball_y_r;
  logic        overlap;
  logic        scan_hit;

  assign play     = (game_state == GS_PLAY);
  assign scan_idx = brick_index(row_q, col_q);

  brick_geom u_scan_geom (
    .row_i (row_q),
    .col_i (col_q),
    .bx0_o (s_bx0),
    .bx1_o (s_bx1),
    .by0_o (s_by0),
    .by1_o (s_by1)
  );

  // Radius is added to whichever side avoids subtracting from the ball
  // coordinate, so nothing can underflow near the screen edge.
  assign ball_x_r = {1'b0, ball_x} + 11'(BALL_RADIUS);
  assign ball_y_r = {1'b0, ball_y} + 11'(BALL_RADIUS);
  assign overlap  = (ball_x_r >= s_bx0) && ({1'b0, ball_x} <= s_bx1 + 11'(BALL_RADIUS)) &&
                    (ball_y_r >= s_by0) && ({1'b0, ball_y} <= s_by1 + 11'(BALL_RADIUS));

  assign scan_hit = play && alive_q[scan_idx] && overlap && (lock_q == '0) && (left_q != '0);

  always_comb begin
    alive_d = alive_q;
    coll_d  = '0;
    score_d = score_q;
    left_d  = left_q;
    win_d   = (left_q == '0);
    row_d   = row_q;
    col_d   = col_q;
    lock_d  = lock_q;
    if (game_reset) begin
      alive_d = '1;
      score_d = '0;
      left_d  = 6'(N_BRICKS);
      win_d   = 1'b0;
      row_d   = '0;
      col_d   = '0;
      lock_d  = '0;
    end else if (play) begin
      if (col_q == 4'(N_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == 3'(N_ROWS - 1)) ? '0 : row_q + 3'd1;
      end else begin
        col_d = col_q + 4'd1;
      end
      if (scan_hit) begin
        alive_d[scan_idx] = 1'b0;
        coll_d            = 50'(1) << scan_idx;
        score_d           = score_q + 6'd1;
        left_d            = left_q - 6'd1;
        lock_d            = LW'(LOCKOUT_CYCLES);
      end else if (lock_q != '0) begin
        lock_d = lock_q - 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      alive_q <= '1;
      coll_q  <= '0;
      score_q <= '0;
      left_q  <= 6'(N_BRICKS);
      win_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      lock_q  <= '0;
    end else begin
      alive_q <= alive_d;
      coll_q  <= coll_d;
      score_q <= score_d;
      left_q  <= left_d;
      win_q   <= win_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lock_q  <= lock_d;
    end
  end

  // Pixel path
  logic [9:0]  pix_y_rel;
  logic [4:0]  prow_full;
  logic [2:0]  prow;
  logic [3:0]  pcol;
  logic [10:0] p_bx0, p_bx1, p_by0, p_by1;
  logic        pix_in;
  logic [5:0]  pix_idx;

  assign pix_y_rel = pix_y - 10'(WALL_Y0);
  assign prow_full = 5'(pix_y_rel >> ROW_PITCH_LOG2);
  assign prow      = prow_full[2:0];
  assign pcol      = pix_x[9:6];
  assign pix_idx   = brick_index(prow, pcol);

  brick_geom u_pix_geom (
    .row_i (prow),
    .col_i (pcol),
    .bx0_o (p_bx0),
    .bx1_o (p_bx1),
    .by0_o (p_by0),
    .by1_o (p_by1)
  );

  assign pix_in = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID)) &&
                  (pix_y >= 10'(WALL_Y0)) && (prow_full < 5'(N_ROWS)) &&
                  ({1'b0, pix_x} >= p_bx0) && ({1'b0, pix_x} <= p_bx1) &&
                  ({1'b0, pix_y} >= p_by0) && ({1'b0, pix_y} <= p_by1);

  assign brick_pix_data  = (pix_in && play && alive_q[pix_idx]) ? row_color(prow) : RGB_BLACK;
  assign brick_collision = coll_q;
  assign score           = score_q;
  assign bricks_left     = left_q;
  assign win_sig         = win_q;

endmodule

// File: tb/tb_brick_wall_logic.sv
module tb_brick_wall_logic;

  localparam int unsigned LOCK = 300;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pix_x, pix_y, ball_x, ball_y;
  logic [1:0]  game_state;
  logic        game_reset;
  logic [49:0] brick_collision;
  logic [15:0] brick_pix_data;
  logic [5:0]  score, bricks_left;
  logic        win_sig;

  int checks = 0;
  int errors = 0;

  brick_wall_logic #(.LOCKOUT_CYCLES(LOCK)) dut (
    .vga_clk         (vga_clk),
    .sys_rst_n       (sys_rst_n),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .game_state      (game_state),
    .game_reset      (game_reset),
    .brick_collision (brick_collision),
    .brick_pix_data  (brick_pix_data),
    .score           (score),
    .bricks_left     (bricks_left),
    .win_sig         (win_sig)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic wait_pulse(input int budget, output logic [49:0] got);
    int n;
    n   = 0;
    got = '0;
    while (n < budget && got == '0) begin
      @(negedge vga_clk);
      n++;
      if (brick_collision != '0) got = brick_collision;
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge vga_clk);
      if (brick_collision != '0) pulses++;
    end
  endtask

  task automatic do_game_reset();
    @(negedge vga_clk);
    game_reset = 1'b1;
    @(negedge vga_clk);
    game_reset = 1'b0;
  endtask

  task automatic ball_far();
    ball_x = 10'd320;
    ball_y = 10'd400;
  endtask

  task automatic test_reset();
    sys_rst_n  = 1'b0;
    game_state = 2'b00;
    game_reset = 1'b0;
    pix_x = 10'd300; pix_y = 10'd45;
    ball_far();
    #23;
    checks++; if (brick_collision !== 50'h0) begin errors++; $display("FAIL reset_coll: got %h expected %h", brick_collision, 50'h0); end
    checks++; if (score !== 6'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (bricks_left !== 6'd50) begin errors++; $display("FAIL reset_left: got %0d expected 50", bricks_left); end
    checks++; if (win_sig !== 1'b0) begin errors++; $display("FAIL reset_win: got %b expected 0", win_sig); end
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    #1;
    checks++; if (brick_pix_data !== 16'h0000) begin errors++; $display("FAIL pix_idle: got %h expected 0000", brick_pix_data); end
    game_state = 2'b01;
    #1;
    checks++; if (brick_pix_data !== 16'hF800) begin errors++; $display("FAIL pix_300_45: got %h expected F800", brick_pix_data); end
    pix_x = 10'd0; #1;
    checks++; if (brick_pix_data !== 16'h0000) begin errors++; $display("FAIL pix_0_45: got %h expected 0000", brick_pix_data); end
    pix_x = 10'd606; pix_y = 10'd178; #1;
    checks++; if (brick_pix_data !== 16'h001F) begin errors++; $display("FAIL pix_last_brick: got %h expected 001F", brick_pix_data); end
    pix_x = 10'd700; pix_y = 10'd45; #1;
    checks++; if (brick_pix_data !== 16'h0000) begin errors++; $display("FAIL pix_offscreen: got %h expected 0000", brick_pix_data); end
  endtask

  task automatic test_single_hit();
    logic [49:0] got;
    int p;
    ball_x = 10'd96; ball_y = 10'd62;
    wait_pulse(51, got);
    checks++; if (got !== 50'h2) begin errors++; $display("FAIL single_pulse: got %h expected %h", got, 50'h2); end
    @(negedge vga_clk);
    checks++; if (brick_collision !== 50'h0) begin errors++; $display("FAIL single_width: got %h expected 0", brick_collision); end
    checks++; if (score !== 6'd1) begin errors++; $display("FAIL single_score: got %0d expected 1", score); end
    checks++; if (bricks_left !== 6'd49) begin errors++; $display("FAIL single_left: got %0d expected 49", bricks_left); end
    pix_x = 10'd96; pix_y = 10'd50; #1;
    checks++; if (brick_pix_data !== 16'h0000) begin errors++; $display("FAIL single_pix_gone: got %h expected 0000", brick_pix_data); end
    count_pulses(100, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL single_no_repeat: got %0d pulses expected 0", p); end
    ball_far();
  endtask

  task automatic test_straddle();
    logic [49:0] first, second;
    int p;
    do_game_reset();
    ball_x = 10'd128; ball_y = 10'd50;
    wait_pulse(51, first);
    checks++; if (first !== 50'h2 && first !== 50'h4) begin errors++; $display("FAIL straddle_first: got %h expected 2 or 4", first); end
    count_pulses(LOCK, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL straddle_lockout: got %0d pulses expected 0", p); end
    wait_pulse(51, second);
    checks++; if ((first | second) !== 50'h6 || first === second) begin errors++; $display("FAIL straddle_second: got %h after %h expected other of 2/4", second, first); end
    @(negedge vga_clk);
    checks++; if (score !== 6'd2 || bricks_left !== 6'd48) begin errors++; $display("FAIL straddle_counts: got score %0d left %0d expected 2 48", score, bricks_left); end
    ball_far();
  endtask

  task automatic test_freeze();
    logic [49:0] got;
    int p;
    do_game_reset();
    game_state = 2'b10;
    ball_x = 10'd96; ball_y = 10'd62;
    count_pulses(1000, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL freeze_pulses: got %0d expected 0", p); end
    checks++; if (score !== 6'd0) begin errors++; $display("FAIL freeze_score: got %0d expected 0", score); end
    pix_x = 10'd96; pix_y = 10'd50; #1;
    checks++; if (brick_pix_data !== 16'h0000) begin errors++; $display("FAIL freeze_pix: got %h expected 0000", brick_pix_data); end
    game_state = 2'b01;
    wait_pulse(51, got);
    checks++; if (got !== 50'h2) begin errors++; $display("FAIL freeze_resume: got %h expected %h", got, 50'h2); end
    ball_far();
  endtask

  task automatic test_reset_mid_lockout();
    logic [49:0] got;
    do_game_reset();
    ball_x = 10'd96; ball_y = 10'd62;
    wait_pulse(51, got);
    checks++; if (got !== 50'h2) begin errors++; $display("FAIL midlock_hit: got %h expected %h", got, 50'h2); end
    repeat (4) @(negedge vga_clk);
    do_game_reset();
    checks++; if (score !== 6'd0 || bricks_left !== 6'd50 || win_sig !== 1'b0) begin errors++; $display("FAIL midlock_counts: got score %0d left %0d win %b expected 0 50 0", score, bricks_left, win_sig); end
    pix_x = 10'd96; pix_y = 10'd50; #1;
    checks++; if (brick_pix_data !== 16'hF800) begin errors++; $display("FAIL midlock_alive: got %h expected F800", brick_pix_data); end
    wait_pulse(51, got);
    checks++; if (got !== 50'h2) begin errors++; $display("FAIL midlock_rehit: got %h expected %h", got, 50'h2); end
    ball_far();
  endtask

  task automatic test_win();
    logic [49:0] got, exp;
    int p;
    do_game_reset();
    for (int i = 0; i < 50; i++) begin
      ball_x = 10'((i % 10) * 64 + 32);
      ball_y = 10'(40 + (i / 10) * 32 + 12);
      exp    = '0;
      exp[i] = 1'b1;
      wait_pulse(LOCK + 60, got);
      checks++; if (got !== exp) begin errors++; $display("FAIL win_hit_%0d: got %h expected %h", i, got, exp); end
      if (i == 48) begin
        checks++; if (bricks_left !== 6'd1 || score !== 6'd49 || win_sig !== 1'b0) begin errors++; $display("FAIL win_49: got left %0d score %0d win %b expected 1 49 0", bricks_left, score, win_sig); end
      end
    end
    checks++; if (bricks_left !== 6'd0 || win_sig !== 1'b0) begin errors++; $display("FAIL win_last: got left %0d win %b expected 0 0", bricks_left, win_sig); end
    @(negedge vga_clk);
    checks++; if (win_sig !== 1'b1 || score !== 6'd50) begin errors++; $display("FAIL win_sig: got win %b score %0d expected 1 50", win_sig, score); end
    ball_x = 10'd32; ball_y = 10'd52;
    count_pulses(LOCK + 100, p);
    checks++; if (p !== 0 || win_sig !== 1'b1) begin errors++; $display("FAIL win_no_more: got %0d pulses win %b expected 0 1", p, win_sig); end
    pix_x = 10'd300; pix_y = 10'd45; #1;
    checks++; if (brick_pix_data !== 16'h0000) begin errors++; $display("FAIL win_pix: got %h expected 0000", brick_pix_data); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_straddle();
    test_freeze();
    test_reset_mid_lockout();
    test_win();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
